// File: rtl/root_xbar.sv
// root_xbar: per-bank round-robin read crossbar between N_REQ NTT/INTT units and
// N_BANK root-power banks, with tagged fixed-latency response return and a DMA broadcast write path.
module root_xbar #(
  parameter int N_REQ  = 4,
  parameter int N_BANK = 2,
  parameter int AW     = 10,
  parameter int DW     = 512,
  parameter int RD_LAT = 1,
  localparam int BW    = (N_BANK > 1) ? $clog2(N_BANK) : 1
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [N_REQ-1:0]              req_valid,
  input  logic [N_REQ-1:0][BW-1:0]      req_bank,
  input  logic [N_REQ-1:0][AW-1:0]      req_addr,
  output logic [N_REQ-1:0]              req_ready,
  output logic [N_REQ-1:0]              rsp_valid,
  output logic [N_REQ-1:0][DW-1:0]      rsp_data,
  output logic                          err_oob,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic [N_BANK-1:0]             wr_mask,
  input  logic [AW-1:0]                 wr_addr,
  input  logic [DW-1:0]                 wr_data,
  output logic [N_BANK-1:0]             bank_ren,
  output logic [N_BANK-1:0][AW-1:0]     bank_raddr,
  input  logic [N_BANK-1:0][DW-1:0]     bank_rdata,
  output logic [N_BANK-1:0]             bank_wen,
  output logic [N_BANK-1:0][AW-1:0]     bank_waddr,
  output logic [N_BANK-1:0][DW-1:0]     bank_wdata
);

  localparam int RW = $clog2(N_REQ);

  logic [N_BANK-1:0][RW-1:0]           rr_r;
  logic [N_BANK-1:0]                   gnt_v_s;
  logic [N_BANK-1:0][RW-1:0]           gnt_id_s;
  logic [N_REQ-1:0]                    ready_s;
  logic [N_REQ-1:0]                    oob_s;
  logic                                wr_acc_s;

  logic [N_BANK-1:0]                   bank_ren_r;
  logic [N_BANK-1:0][AW-1:0]           bank_raddr_r;
  logic [N_BANK-1:0][RD_LAT:0]         tag_v_r;
  logic [N_BANK-1:0][RD_LAT:0][RW-1:0] tag_id_r;
  logic [RD_LAT:0][N_REQ-1:0]          oob_pipe_r;

  logic [N_REQ-1:0]                    rsp_hit_s;
  logic [N_REQ-1:0][DW-1:0]            rsp_nxt_s;
  logic [N_REQ-1:0]                    rsp_valid_r;
  logic [N_REQ-1:0][DW-1:0]            rsp_data_r;
  logic                                err_oob_r;

  logic                                wr_ready_r;
  logic [N_BANK-1:0]                   bank_wen_r;
  logic [AW-1:0]                       waddr_r;
  logic [DW-1:0]                       wdata_r;

  // Requester index base+off wrapped into 0..N_REQ-1.
  function automatic logic [RW-1:0] rr_idx(input logic [RW-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    return RW'(sum % N_REQ);
  endfunction

  assign wr_acc_s = wr_valid & wr_ready_r;

  // Arbitration: OOB requests accept immediately; in-range banks pick the first requester from rr.
  always_comb begin
    gnt_v_s  = '0;
    gnt_id_s = '0;
    ready_s  = '0;
    oob_s    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      oob_s[i]   = req_valid[i] && (int'(req_bank[i]) >= N_BANK);
      ready_s[i] = oob_s[i];
    end
    for (int b = 0; b < N_BANK; b++) begin
      for (int j = 0; j < N_REQ; j++) begin
        logic [RW-1:0] k;
        logic          hit;
        k   = rr_idx(rr_r[b], j);
        hit = !(wr_acc_s && wr_mask[b]) && !gnt_v_s[b] && req_valid[k]
              && (int'(req_bank[k]) == b);
        gnt_id_s[b] = hit ? k : gnt_id_s[b];
        gnt_v_s[b]  = gnt_v_s[b] | hit;
        ready_s[k]  = ready_s[k] | hit;
      end
    end
  end

  assign req_ready = ready_s;

  // Pointer update and bank read-command registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rr_r         <= '0;
      bank_ren_r   <= '0;
      bank_raddr_r <= '0;
    end else begin
      for (int b = 0; b < N_BANK; b++) begin
        rr_r[b]         <= gnt_v_s[b] ? rr_idx(gnt_id_s[b], 1) : rr_r[b];
        bank_raddr_r[b] <= gnt_v_s[b] ? req_addr[gnt_id_s[b]] : bank_raddr_r[b];
      end
      bank_ren_r <= gnt_v_s;
    end
  end

  // In-flight tags; stage RD_LAT lines up with bank_rdata of the matching read.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tag_v_r    <= '0;
      tag_id_r   <= '0;
      oob_pipe_r <= '0;
    end else begin
      for (int b = 0; b < N_BANK; b++) begin
        tag_v_r[b]  <= {tag_v_r[b][RD_LAT-1:0], gnt_v_s[b]};
        tag_id_r[b] <= {tag_id_r[b][RD_LAT-1:0], gnt_id_s[b]};
      end
      oob_pipe_r <= {oob_pipe_r[RD_LAT-1:0], oob_s};
    end
  end

  // Steer returning bank data (or zero for OOB) to the tagged requester.
  always_comb begin
    rsp_hit_s = '0;
    rsp_nxt_s = rsp_data_r;
    for (int b = 0; b < N_BANK; b++) begin
      for (int i = 0; i < N_REQ; i++) begin
        logic sel;
        sel          = tag_v_r[b][RD_LAT] && (tag_id_r[b][RD_LAT] == RW'(i));
        rsp_nxt_s[i] = sel ? bank_rdata[b] : rsp_nxt_s[i];
        rsp_hit_s[i] = rsp_hit_s[i] | sel;
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      rsp_nxt_s[i] = oob_pipe_r[RD_LAT][i] ? {DW{1'b0}} : rsp_nxt_s[i];
      rsp_hit_s[i] = rsp_hit_s[i] | oob_pipe_r[RD_LAT][i];
    end
  end

  // Response registers and sticky out-of-range flag.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rsp_valid_r <= '0;
      rsp_data_r  <= '0;
      err_oob_r   <= 1'b0;
    end else begin
      rsp_valid_r <= rsp_hit_s;
      rsp_data_r  <= rsp_nxt_s;
      err_oob_r   <= err_oob_r | (|oob_s);
    end
  end

  // DMA write path: one registered copy broadcast to every bank, enables from the mask.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ready_r <= 1'b0;
      bank_wen_r <= '0;
      waddr_r    <= '0;
      wdata_r    <= '0;
    end else begin
      wr_ready_r <= 1'b1;
      bank_wen_r <= wr_acc_s ? wr_mask : {N_BANK{1'b0}};
      waddr_r    <= wr_acc_s ? wr_addr : waddr_r;
      wdata_r    <= wr_acc_s ? wr_data : wdata_r;
    end
  end

  assign rsp_valid  = rsp_valid_r;
  assign rsp_data   = rsp_data_r;
  assign err_oob    = err_oob_r;
  assign wr_ready   = wr_ready_r;
  assign bank_ren   = bank_ren_r;
  assign bank_raddr = bank_raddr_r;
  assign bank_wen   = bank_wen_r;
  assign bank_waddr = {N_BANK{waddr_r}};
  assign bank_wdata = {N_BANK{wdata_r}};

endmodule

// File: tb/tb_root_xbar.sv
// Scoreboard bench for root_xbar: a per-cycle reference arbiter predicts req_ready and queues
// expected responses; a monitor pops and compares whenever the DUT presents rsp_valid.
module tb_root_xbar;
  localparam int N_REQ = 4, N_BANK = 3, AW = 10, DW = 64, RD_LAT = 1, BW = 2;

  logic                         clk = 1'b0;
  logic                         rstn = 1'b0;
  logic [N_REQ-1:0]             req_valid = '0;
  logic [N_REQ-1:0][BW-1:0]     req_bank = '0;
  logic [N_REQ-1:0][AW-1:0]     req_addr = '0;
  logic [N_REQ-1:0]             req_ready;
  logic [N_REQ-1:0]             rsp_valid;
  logic [N_REQ-1:0][DW-1:0]     rsp_data;
  logic                         err_oob;
  logic                         wr_valid = 1'b0;
  logic                         wr_ready;
  logic [N_BANK-1:0]            wr_mask = '0;
  logic [AW-1:0]                wr_addr = '0;
  logic [DW-1:0]                wr_data = '0;
  logic [N_BANK-1:0]            bank_ren;
  logic [N_BANK-1:0][AW-1:0]    bank_raddr;
  logic [N_BANK-1:0][DW-1:0]    bank_rdata = '0;
  logic [N_BANK-1:0]            bank_wen;
  logic [N_BANK-1:0][AW-1:0]    bank_waddr;
  logic [N_BANK-1:0][DW-1:0]    bank_wdata;

  root_xbar #(.N_REQ(N_REQ), .N_BANK(N_BANK), .AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_bank(req_bank), .req_addr(req_addr), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .err_oob(err_oob),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_mask(wr_mask), .wr_addr(wr_addr),
    .wr_data(wr_data), .bank_ren(bank_ren), .bank_raddr(bank_raddr), .bank_rdata(bank_rdata),
    .bank_wen(bank_wen), .bank_waddr(bank_waddr), .bank_wdata(bank_wdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Bank RAM models (RD_LAT = 1), separate from the reference memory below.
  logic [DW-1:0] ram [N_BANK][1024];
  always @(posedge clk) begin
    for (int b = 0; b < N_BANK; b++) begin
      if (bank_wen[b]) ram[b][bank_waddr[b]] <= bank_wdata[b];
      if (bank_ren[b]) bank_rdata[b] <= ram[b][bank_raddr[b]];
    end
  end

  typedef struct { logic [DW-1:0] data; int cyc; } exp_t;
  exp_t              exp_q [N_REQ][$];
  logic [DW-1:0]     ref_mem [N_BANK][1024];
  int                rr_m [N_BANK];
  logic [N_BANK-1:0] wen_exp [int];
  int                err_from = -1;
  int                checks = 0;
  int                passes = 0;

  function automatic logic [DW-1:0] init_val(int b, int a);
    return (64'(b) << 32) | 64'(a);
  endfunction

  task automatic check(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
  endtask

  task automatic push(int i, logic [DW-1:0] d);
    exp_t e;
    e.data = d;
    e.cyc  = cyc + RD_LAT + 2;
    exp_q[i].push_back(e);
  endtask

  // One input cycle: predict grants from the rules, check req_ready, record expectations.
  task automatic step();
    logic [N_REQ-1:0] rdy;
    #1;
    rdy = '0;
    for (int b = 0; b < N_BANK; b++) begin
      int best, bestd;
      best = -1;
      bestd = N_REQ;
      if (!(wr_valid && wr_mask[b])) begin
        for (int i = 0; i < N_REQ; i++) begin
          int d;
          d = (i - rr_m[b] + N_REQ) % N_REQ;
          if (req_valid[i] && int'(req_bank[i]) == b && d < bestd) begin
            best = i;
            bestd = d;
          end
        end
      end
      if (best >= 0) begin
        rdy[best] = 1'b1;
        rr_m[b] = (best + 1) % N_REQ;
        push(best, ref_mem[b][req_addr[best]]);
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (req_valid[i] && int'(req_bank[i]) >= N_BANK) begin
        rdy[i] = 1'b1;
        push(i, '0);
        if (err_from < 0) err_from = cyc + 1;
      end
    end
    check("req_ready", 64'(req_ready), 64'(rdy));
    if (wr_valid) begin
      for (int b = 0; b < N_BANK; b++)
        if (wr_mask[b]) ref_mem[b][wr_addr] = wr_data;
      wen_exp[cyc + 1] = wr_mask;
    end
    @(negedge clk);
  endtask

  task automatic idle(int n);
    req_valid = '0;
    wr_valid = 1'b0;
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic model_reset();
    for (int i = 0; i < N_REQ; i++) exp_q[i].delete();
    for (int b = 0; b < N_BANK; b++) rr_m[b] = 0;
    wen_exp.delete();
    err_from = -1;
  endtask

  // Monitor: compares responses, write enables and flags one tick after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!rstn) begin
        check("reset_outputs", 64'({rsp_valid, bank_ren, bank_wen, err_oob, wr_ready}), 64'(0));
      end else begin
        for (int i = 0; i < N_REQ; i++) begin
          while (exp_q[i].size() > 0 && exp_q[i][0].cyc < cyc) begin
            check("rsp_missing", 64'(0), 64'(1));
            void'(exp_q[i].pop_front());
          end
          if (rsp_valid[i]) begin
            if (exp_q[i].size() == 0) begin
              check("rsp_unexpected", 64'(1), 64'(0));
            end else begin
              exp_t e;
              e = exp_q[i].pop_front();
              check("rsp_data", rsp_data[i], e.data);
              check("rsp_cycle", 64'(cyc), 64'(e.cyc));
            end
          end
        end
        check("bank_wen", 64'(bank_wen), 64'(wen_exp.exists(cyc) ? wen_exp[cyc] : '0));
        check("err_oob", 64'(err_oob), 64'(err_from >= 0 && cyc >= err_from));
        check("wr_ready", 64'(wr_ready), 64'(1));
      end
    end
  end

  initial begin
    for (int b = 0; b < N_BANK; b++) begin
      rr_m[b] = 0;
      for (int a = 0; a < 1024; a++) begin
        ram[b][a] = init_val(b, a);
        ref_mem[b][a] = init_val(b, a);
      end
    end
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    idle(3);

    // Single read: req0 -> bank1 addr 5.
    req_valid = 4'b0001; req_bank[0] = 2'd1; req_addr[0] = 10'h005;
    step();
    idle(4);

    // Round robin: all four on bank0, each with its own address.
    for (int i = 0; i < N_REQ; i++) begin
      req_bank[i] = 2'd0;
      req_addr[i] = AW'(32'h10 + i);
    end
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) step();
    idle(4);

    // Parallel banks.
    req_valid = 4'b0011;
    req_bank[0] = 2'd0; req_addr[0] = 10'h020;
    req_bank[1] = 2'd1; req_addr[1] = 10'h021;
    step();
    idle(4);

    // Broadcast write with a same-cycle read to a masked bank, then read-back from both banks.
    wr_valid = 1'b1; wr_mask = 3'b011; wr_addr = 10'h007; wr_data = 64'hABAB_ABAB_ABAB_ABAB;
    req_valid = 4'b0100; req_bank[2] = 2'd0; req_addr[2] = 10'h007;
    step();
    wr_valid = 1'b0;
    req_valid = 4'b0101; req_bank[0] = 2'd1; req_addr[0] = 10'h007;
    step();
    idle(4);

    // Out-of-range bank.
    req_valid = 4'b1000; req_bank[3] = 2'd3; req_addr[3] = 10'h0AA;
    step();
    idle(4);

    // Randomized traffic with writes.
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < N_REQ; i++) begin
        req_valid[i] = ($urandom_range(0, 3) != 0);
        req_bank[i]  = ($urandom_range(0, 9) == 0) ? 2'd3 : BW'($urandom_range(0, 2));
        req_addr[i]  = AW'($urandom_range(0, 15));
      end
      wr_valid = ($urandom_range(0, 3) == 0);
      wr_mask  = N_BANK'($urandom_range(0, 7));
      wr_addr  = AW'($urandom_range(0, 15));
      wr_data  = {$urandom, $urandom};
      step();
    end
    idle(5);

    // Reset mid-flight: advance rr, grant once more, then reset one cycle later.
    for (int i = 0; i < N_REQ; i++) begin
      req_bank[i] = 2'd0;
      req_addr[i] = AW'(32'h30 + i);
    end
    req_valid = 4'b1111;
    step();
    step();
    req_valid = '0;
    step();
    rstn = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    req_valid = 4'b1111;
    for (int k = 0; k < 4; k++) step();
    idle(6);

    for (int i = 0; i < N_REQ; i++) check("drain_empty", 64'(exp_q[i].size()), 64'(0));
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
